// File: rtl/seq_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_div_pkg : shared types and constants for the signed divider    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Sliced down to the operand width by the divider
    localparam logic [31:0] DIV0_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_divider_if : start/busy/done handshake and operand/result bus  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface seq_divider_if #(
    parameter int dw = 8
);
    logic          start;
    logic [dw-1:0] dividend;
    logic [dw-1:0] divisor;
    logic          busy;
    logic          done;
    logic [dw-1:0] quotient;
    logic [dw-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/counter_up.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_up : iteration counter, tc flags result == WIDTH and wraps |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_up #(
    parameter int dw    = 3,
    parameter int WIDTH = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          ena,
    output logic [dw-1:0] result,
    output logic          tc
);
    localparam logic [dw-1:0] TC_VALUE = dw'(WIDTH);

    assign tc = (result == TC_VALUE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
        end else if (clr) begin
            result <= '0;
        end else if (ena) begin
            result <= tc ? '0 : result + dw'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_divider : signed restoring divider, one quotient bit per clock |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int dw = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int            CW      = $clog2(dw);
    localparam logic [dw-1:0] MIN_NEG = {1'b1, {(dw-1){1'b0}}};

    function automatic logic [dw-1:0] magnitude(input logic [dw-1:0] x);
        return x[dw-1] ? -x : x;
    endfunction

    state_t        state;
    logic          sign_q;
    logic          sign_r;
    logic [dw-1:0] acc_q;
    logic [dw-1:0] part_rem;
    logic [dw-1:0] mag_dvs;
    logic [dw-1:0] dvd_lat;
    logic [dw-1:0] dvs_lat;
    logic          busy;
    logic          done;
    logic [dw-1:0] quotient;
    logic [dw-1:0] remainder;
    logic          div_by_zero;
    logic          overflow;

    logic [dw:0]   shifted_rem;
    logic [dw:0]   trial;
    logic          cnt_clr;
    logic          cnt_ena;
    logic          cnt_tc;
    logic [CW-1:0] iter_cnt;
    logic          unused_iter_cnt;

    // The kept remainder is always below |divisor|, so dw bits hold it;
    // the extra bit only exists in the shifted trial value.
    assign shifted_rem     = {part_rem, acc_q[dw-1]};
    assign trial           = shifted_rem - {1'b0, mag_dvs};
    assign cnt_clr         = (state == IDLE);
    assign cnt_ena         = (state == CALC);
    assign unused_iter_cnt = ^iter_cnt;

    counter_up #(
        .dw    (CW),
        .WIDTH (dw - 1)
    ) u_iter_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .ena    (cnt_ena),
        .result (iter_cnt),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            acc_q       <= '0;
            part_rem    <= '0;
            mag_dvs     <= '0;
            dvd_lat     <= '0;
            dvs_lat     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sign_q      <= bus.dividend[dw-1] ^ bus.divisor[dw-1];
                        sign_r      <= bus.dividend[dw-1];
                        acc_q       <= magnitude(bus.dividend);
                        mag_dvs     <= magnitude(bus.divisor);
                        dvd_lat     <= bus.dividend;
                        dvs_lat     <= bus.divisor;
                        part_rem    <= '0;
                        busy        <= 1'b1;
                        overflow    <= 1'b0;
                        div_by_zero <= (bus.divisor == '0);
                        state       <= (bus.divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (!trial[dw]) begin
                        part_rem <= trial[dw-1:0];
                        acc_q    <= {acc_q[dw-2:0], 1'b1};
                    end else begin
                        part_rem <= shifted_rem[dw-1:0];
                        acc_q    <= {acc_q[dw-2:0], 1'b0};
                    end
                    if (cnt_tc) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_by_zero) begin
                        quotient  <= DIV0_QUOT[dw-1:0];
                        remainder <= dvd_lat;
                    end else begin
                        quotient  <= sign_q ? -acc_q : acc_q;
                        remainder <= sign_r ? -part_rem : part_rem;
                    end
                    overflow <= (dvd_lat == MIN_NEG) && (dvs_lat == '1);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
    assign bus.overflow    = overflow;
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seq_divider : directed vectors with a queue-based scoreboard    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_seq_divider;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        logic          dbz;
        logic          ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    exp_t sb[$];
    int   asserts    = 0;
    int   failures   = 0;
    int   done_count = 0;

    seq_divider_if #(.dw(DW)) bus ();

    seq_divider #(.dw(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        asserts++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_count++;
            check("scoreboard_not_empty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("quotient",    32'(bus.quotient),    32'(e.q));
                check("remainder",   32'(bus.remainder),   32'(e.r));
                check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                check("overflow",    32'(bus.overflow),    32'(e.ovf));
            end
        end
    end

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] q, input logic [DW-1:0] r,
                          input logic dbz, input logic ovf, input int lat);
        int n;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        sb.push_back('{q: q, r: r, dbz: dbz, ovf: ovf});
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", 32'(n), 32'(lat));
        check("busy_low_at_done", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dc0;
        int idx[$];
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        reset        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}),
              32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(8'd100, 8'd7,  8'd14,  8'd2,  1'b0, 1'b0, 9);
        run_op(8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, 1'b0, 9);   // -100 / 7
        run_op(8'd100, 8'hF9, 8'hF2,  8'd2,  1'b0, 1'b0, 9);   // 100 / -7
        run_op(8'h9C,  8'hF9, 8'd14,  8'hFE, 1'b0, 1'b0, 9);   // -100 / -7
        run_op(8'd5,   8'd0,  8'hFF,  8'd5,  1'b1, 1'b0, 1);
        run_op(8'd9,   8'd3,  8'd3,   8'd0,  1'b0, 1'b0, 9);
        run_op(8'h80,  8'hFF, 8'h80,  8'd0,  1'b0, 1'b1, 9);   // -128 / -1
        run_op(8'h80,  8'd1,  8'h80,  8'd0,  1'b0, 1'b0, 9);   // -128 / 1

        // A second start while in CALC must be ignored
        dc0          = done_count;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        sb.push_back('{q: 8'd14, r: 8'd2, dbz: 1'b0, ovf: 1'b0});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'd77;
        repeat (20) @(posedge clk);
        #1;
        check("mid_calc_start_single_done", 32'(done_count - dc0), 32'd1);

        // Reset during CALC abandons the operation
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dc0   = done_count;
        reset = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_calc_outputs",
              32'({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}),
              32'd0);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_mid_calc_no_done", 32'(done_count - dc0), 32'd0);
        @(posedge clk); #1;
        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9);

        // Start held high: accepted at edges 0, 11, 22
        bus.dividend = 8'd7;
        bus.divisor  = 8'd2;
        bus.start    = 1'b1;
        repeat (3) sb.push_back('{q: 8'd3, r: 8'd1, dbz: 1'b0, ovf: 1'b0});
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (k == 29) bus.start = 1'b0;
            if (bus.done === 1'b1) idx.push_back(k);
        end
        check("held_start_done_count", 32'(idx.size()), 32'd3);
        if (idx.size() == 3) begin
            check("held_start_first_done", 32'(idx[0]), 32'd9);
            check("held_start_gap_1", 32'(idx[1] - idx[0]), 32'd11);
            check("held_start_gap_2", 32'(idx[2] - idx[1]), 32'd11);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
`default_nettype wire
